// File: rtl/cpu_control_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_control_sequencer
//
// Seven-step stepper and instruction decoder for the CPU_B datapath. A one-hot
// step register walks step1..step7 while `run` is high. Steps 1-3 fetch the
// next instruction into the IR. Steps 4-6 decode `ir` (and `flags` for the
// conditional jump) into per-step set/enable strobes and the ALU opcode.
// Step7 is idle.
//
// Ports
//   clk      in   1  system clock, rising edge
//   reset    in   1  synchronous, active-high; forces step1 and silences outputs
//   run      in   1  advance enable; low holds the current step and its outputs
//   ir       in   8  instruction register: [7]=ALU, [6:4]=op, [3:2]=RA, [1:0]=RB
//   flags    in   4  flags register: [3]=C, [2]=A, [1]=E, [0]=Z
//   step     out  7  one-hot step; [0]=step1 .. [6]=step7
//   bus1     out  1  drive 8'h01 through the bus-1 gate
//   s_mar, s_acc, s_iar, s_ir, s_tmp, s_flags, s_ram   out 1  register set strobes
//   e_ram, e_acc, e_iar                                out 1  bus enables
//   s_reg    out  4  one-hot set strobes for R0..R3
//   e_reg    out  4  one-hot bus enables for R0..R3
//   alu_op   out  3  ALU operation; ADD (3'b000) unless an ALU step is active
// -----------------------------------------------------------------------------
module cpu_control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] ir,
    input  logic [3:0] flags,
    output logic [6:0] step,
    output logic       bus1,
    output logic       s_mar,
    output logic       s_acc,
    output logic       s_iar,
    output logic       s_ir,
    output logic       s_tmp,
    output logic       s_flags,
    output logic       s_ram,
    output logic       e_ram,
    output logic       e_acc,
    output logic       e_iar,
    output logic [3:0] s_reg,
    output logic [3:0] e_reg,
    output logic [2:0] alu_op
);

    typedef enum logic [6:0] {
        STEP1 = 7'b0000001,
        STEP2 = 7'b0000010,
        STEP3 = 7'b0000100,
        STEP4 = 7'b0001000,
        STEP5 = 7'b0010000,
        STEP6 = 7'b0100000,
        STEP7 = 7'b1000000
    } step_e;

    // Non-ALU instruction classes, decoded from ir[6:4] when ir[7]=0.
    typedef enum logic [2:0] {
        OP_LD    = 3'b000,
        OP_ST    = 3'b001,
        OP_DATA  = 3'b010,
        OP_JMPR  = 3'b011,
        OP_JMP   = 3'b100,
        OP_JCAEZ = 3'b101,
        OP_CLF   = 3'b110,
        OP_IO    = 3'b111
    } op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_CMP = 3'b111;

    step_e      step_q;
    step_e      step_n;

    logic       alu_inst;
    op_e        op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       jump_taken;

    assign alu_inst   = ir[7];
    assign op         = op_e'(ir[6:4]);
    assign ra         = ir[3:2];
    assign rb         = ir[1:0];
    // Conditional jump fires when any flag selected by ir[3:0] is set.
    assign jump_taken = |(ir[3:0] & flags);

    // ------------------------------------------------------------------------
    // Step register
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= STEP1;
        end else begin
            step_q <= step_n;
        end
    end

    // Rotate left on run; any non-one-hot value (X or upset) falls to the
    // default and restarts at step1 on the next edge, whatever `run` is.
    always_comb begin
        step_n = step_q;
        case (step_q)
            STEP1:   if (run) step_n = STEP2;
            STEP2:   if (run) step_n = STEP3;
            STEP3:   if (run) step_n = STEP4;
            STEP4:   if (run) step_n = STEP5;
            STEP5:   if (run) step_n = STEP6;
            STEP6:   if (run) step_n = STEP7;
            STEP7:   if (run) step_n = STEP1;
            default: step_n = STEP1;
        endcase
    end

    // The register already holds step1 after any reset edge; this covers the
    // first reset cycle so `step` reads step1 for the whole reset window.
    assign step = reset ? STEP1 : step_q;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned; an unassigned path would infer a latch.
    always_comb begin
        bus1    = 1'b0;
        s_mar   = 1'b0;
        s_acc   = 1'b0;
        s_iar   = 1'b0;
        s_ir    = 1'b0;
        s_tmp   = 1'b0;
        s_flags = 1'b0;
        s_ram   = 1'b0;
        e_ram   = 1'b0;
        e_acc   = 1'b0;
        e_iar   = 1'b0;
        s_reg   = 4'b0000;
        e_reg   = 4'b0000;
        alu_op  = ALU_ADD;

        if (!reset) begin
            case (step_q)
                // Fetch: MAR <= IAR, ACC <= IAR + 1.
                STEP1: begin
                    bus1  = 1'b1;
                    e_iar = 1'b1;
                    s_mar = 1'b1;
                    s_acc = 1'b1;
                end
                // IR <= RAM[MAR].
                STEP2: begin
                    e_ram = 1'b1;
                    s_ir  = 1'b1;
                end
                // IAR <= ACC.
                STEP3: begin
                    e_acc = 1'b1;
                    s_iar = 1'b1;
                end
                STEP4: begin
                    if (alu_inst) begin
                        e_reg[rb] = 1'b1;
                        s_tmp     = 1'b1;
                    end else begin
                        case (op)
                            OP_LD, OP_ST: begin
                                e_reg[ra] = 1'b1;
                                s_mar     = 1'b1;
                            end
                            // Both read the in-line operand byte and bump IAR
                            // past it, reusing the step1 fetch pattern.
                            OP_DATA, OP_JCAEZ: begin
                                bus1  = 1'b1;
                                e_iar = 1'b1;
                                s_mar = 1'b1;
                                s_acc = 1'b1;
                            end
                            OP_JMPR: begin
                                e_reg[rb] = 1'b1;
                                s_iar     = 1'b1;
                            end
                            OP_JMP: begin
                                e_iar = 1'b1;
                                s_mar = 1'b1;
                            end
                            // Clear flags: bus1 with ADD on a zeroed TMP path.
                            OP_CLF: begin
                                bus1    = 1'b1;
                                s_flags = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                STEP5: begin
                    if (alu_inst) begin
                        e_reg[ra] = 1'b1;
                        alu_op    = ir[6:4];
                        s_flags   = 1'b1;
                        // CMP only updates flags; the accumulator is untouched.
                        s_acc     = (ir[6:4] != ALU_CMP);
                    end else begin
                        case (op)
                            OP_LD, OP_DATA: begin
                                e_ram     = 1'b1;
                                s_reg[rb] = 1'b1;
                            end
                            OP_ST: begin
                                e_reg[rb] = 1'b1;
                                s_ram     = 1'b1;
                            end
                            OP_JMP: begin
                                e_ram = 1'b1;
                                s_iar = 1'b1;
                            end
                            // Fall-through address becomes the new IAR first.
                            OP_JCAEZ: begin
                                e_acc = 1'b1;
                                s_iar = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                STEP6: begin
                    if (alu_inst) begin
                        if (ir[6:4] != ALU_CMP) begin
                            e_acc     = 1'b1;
                            s_reg[rb] = 1'b1;
                        end
                    end else begin
                        case (op)
                            OP_DATA: begin
                                e_acc = 1'b1;
                                s_iar = 1'b1;
                            end
                            // Taken branch overwrites IAR with the operand byte.
                            OP_JCAEZ: begin
                                if (jump_taken) begin
                                    e_ram = 1'b1;
                                    s_iar = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_sequencer
//
// Directed bench for cpu_control_sequencer. A behavioural model tracks the
// step number as an integer 1..7 and derives the expected control word from
// the instruction tables; a compare process checks every cycle on the falling
// edge. Literal expectations at the directed points pin both DUT and model.
// -----------------------------------------------------------------------------
module tb_cpu_control_sequencer;

    typedef struct packed {
        logic [6:0] step;
        logic       bus1;
        logic       s_mar;
        logic       s_acc;
        logic       s_iar;
        logic       s_ir;
        logic       s_tmp;
        logic       s_flags;
        logic       s_ram;
        logic       e_ram;
        logic       e_acc;
        logic       e_iar;
        logic [3:0] s_reg;
        logic [3:0] e_reg;
        logic [2:0] alu_op;
    } ctl_t;

    logic       clk;
    logic       reset;
    logic       run;
    logic [7:0] ir;
    logic [3:0] flags;
    logic [6:0] step;
    logic       bus1, s_mar, s_acc, s_iar, s_ir, s_tmp, s_flags, s_ram;
    logic       e_ram, e_acc, e_iar;
    logic [3:0] s_reg, e_reg;
    logic [2:0] alu_op;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_control_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .ir      (ir),
        .flags   (flags),
        .step    (step),
        .bus1    (bus1),
        .s_mar   (s_mar),
        .s_acc   (s_acc),
        .s_iar   (s_iar),
        .s_ir    (s_ir),
        .s_tmp   (s_tmp),
        .s_flags (s_flags),
        .s_ram   (s_ram),
        .e_ram   (e_ram),
        .e_acc   (e_acc),
        .e_iar   (e_iar),
        .s_reg   (s_reg),
        .e_reg   (e_reg),
        .alu_op  (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctl_t act;
    assign act = {step, bus1, s_mar, s_acc, s_iar, s_ir, s_tmp, s_flags, s_ram,
                  e_ram, e_acc, e_iar, s_reg, e_reg, alu_op};

    // All control outputs without the step field.
    logic [21:0] outs;
    assign outs = act[21:0];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: step number plus instruction tables
    // ------------------------------------------------------------------------
    int m_step = 1;

    always @(posedge clk) begin
        if (reset)    m_step <= 1;
        else if (run) m_step <= (m_step == 7) ? 1 : m_step + 1;
    end

    function automatic ctl_t model_out(int s, logic [7:0] i, logic [3:0] f, logic rst);
        ctl_t       c;
        int         ra;
        int         rb;
        logic [2:0] op;
        c      = '0;
        ra     = int'(i[3:2]);
        rb     = int'(i[1:0]);
        op     = i[6:4];
        c.step = 7'(1 << (s - 1));
        if (rst) begin
            c.step = 7'b0000001;
            return c;
        end
        // Step1 pattern, also used as step4 of DATA and JCAEZ.
        if (s == 1 || (s == 4 && !i[7] && (op == 3'd2 || op == 3'd5))) begin
            c.bus1 = 1; c.e_iar = 1; c.s_mar = 1; c.s_acc = 1;
        end else if (s == 2) begin
            c.e_ram = 1; c.s_ir = 1;
        end else if (s == 3) begin
            c.e_acc = 1; c.s_iar = 1;
        end else if (s >= 4 && s <= 6) begin
            if (i[7]) begin
                if (s == 4) begin
                    c.e_reg[rb] = 1; c.s_tmp = 1;
                end else if (s == 5) begin
                    c.e_reg[ra] = 1; c.alu_op = op; c.s_flags = 1;
                    c.s_acc = (op != 3'd7);
                end else if (op != 3'd7) begin
                    c.e_acc = 1; c.s_reg[rb] = 1;
                end
            end else begin
                case ({op, 4'(s)})
                    {3'd0, 4'd4}, {3'd1, 4'd4}: begin c.e_reg[ra] = 1; c.s_mar = 1; end
                    {3'd0, 4'd5}, {3'd2, 4'd5}: begin c.e_ram = 1; c.s_reg[rb] = 1; end
                    {3'd1, 4'd5}: begin c.e_reg[rb] = 1; c.s_ram = 1; end
                    {3'd2, 4'd6}, {3'd5, 4'd5}: begin c.e_acc = 1; c.s_iar = 1; end
                    {3'd3, 4'd4}: begin c.e_reg[rb] = 1; c.s_iar = 1; end
                    {3'd4, 4'd4}: begin c.e_iar = 1; c.s_mar = 1; end
                    {3'd4, 4'd5}: begin c.e_ram = 1; c.s_iar = 1; end
                    {3'd5, 4'd6}: if ((i[3:0] & f) != 4'd0) begin c.e_ram = 1; c.s_iar = 1; end
                    {3'd6, 4'd4}: begin c.bus1 = 1; c.s_flags = 1; end
                    default: ;
                endcase
            end
        end
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Per-cycle compare on the falling edge
    // ------------------------------------------------------------------------
    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_model", 32'(act), 32'(model_out(m_step, ir, flags, reset)));
            check("bus_onehot", 32'($countones({e_ram, e_acc, e_iar, e_reg}) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    logic [7:0] sweep_ir [10];

    initial begin
        sweep_ir = '{8'h0E, 8'h1B, 8'h3D, 8'h40, 8'h60, 8'h70, 8'h9F, 8'hC5, 8'hB4, 8'h54};

        reset = 1'b1;
        run   = 1'b0;
        ir    = 8'h00;
        flags = 4'h0;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_step", 32'(step), 32'h01);
        check("rst_outs", 32'(outs), 32'h0);

        // Fetch and ADD R1,R2.
        reset = 1'b0;
        run   = 1'b1;
        ir    = 8'h86;
        #1;
        check("s1_step", 32'(step), 32'h01);
        check("s1_fetch", 32'({bus1, e_iar, s_mar, s_acc}), 32'hF);
        tick();
        check("s2_step", 32'(step), 32'h02);
        check("s2_ir", 32'({e_ram, s_ir}), 32'h3);
        tick();
        check("s3_step", 32'(step), 32'h04);
        check("s3_iar", 32'({e_acc, s_iar}), 32'h3);
        tick();
        check("add_s4_step", 32'(step), 32'h08);
        check("add_s4_ereg", 32'(e_reg), 32'b0100);
        check("add_s4_tmp", 32'(s_tmp), 32'h1);
        tick();
        check("add_s5_ereg", 32'(e_reg), 32'b0010);
        check("add_s5_op", 32'(alu_op), 32'h0);
        check("add_s5_set", 32'({s_acc, s_flags}), 32'h3);
        tick();
        check("add_s6_eacc", 32'(e_acc), 32'h1);
        check("add_s6_sreg", 32'(s_reg), 32'b0100);
        tick();
        check("s7_step", 32'(step), 32'h40);
        check("s7_outs", 32'(outs), 32'h0);
        tick();
        check("wrap_step", 32'(step), 32'h01);

        // CMP.
        ir = 8'hF6;
        ticks(4);
        check("cmp_s5_op", 32'(alu_op), 32'h7);
        check("cmp_s5_set", 32'({s_acc, s_flags}), 32'h1);
        tick();
        check("cmp_s6_outs", 32'(outs), 32'h0);
        ticks(2);

        // JC taken, then not taken.
        ir    = 8'h58;
        flags = 4'b1000;
        ticks(5);
        check("jc_taken", 32'({e_ram, s_iar}), 32'h3);
        ticks(2);
        flags = 4'b0111;
        ticks(5);
        check("jc_not_taken", 32'(outs), 32'h0);
        ticks(2);

        // DATA R3.
        ir    = 8'h23;
        flags = 4'h0;
        ticks(3);
        check("data_s4", 32'({bus1, e_iar, s_mar, s_acc}), 32'hF);
        tick();
        check("data_s5", 32'({e_ram, s_reg}), 32'b11000);
        tick();
        check("data_s6", 32'({e_acc, s_iar}), 32'h3);
        ticks(2);

        // Hold at step5 of ADD, then reset in step6.
        ir = 8'h86;
        ticks(4);
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_step", 32'(step), 32'h10);
            check("hold_outs", 32'({e_reg, s_acc, s_flags}), 32'b001011);
        end
        run = 1'b1;
        tick();
        check("pre_rst_step", 32'(step), 32'h20);
        reset = 1'b1;
        #1;
        check("midrst_step", 32'(step), 32'h01);
        check("midrst_outs", 32'(outs), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_step", 32'(step), 32'h01);
        check("post_rst_fetch", 32'({bus1, e_iar, s_mar, s_acc}), 32'hF);

        // Remaining instruction classes; the model checks every cycle.
        for (int n = 0; n < 10; n++) begin
            ir    = sweep_ir[n];
            flags = 4'($urandom);
            ticks(7);
        end

        // Random run, ir, flags and occasional reset.
        for (int n = 0; n < 120; n++) begin
            run   = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 24) == 0);
            ir    = 8'($urandom);
            flags = 4'($urandom);
            tick();
        end
        reset = 1'b0;
        run   = 1'b1;
        ticks(2);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
